hs_protocol_monitor: RTL and testbench

HS_PROTOCOL_MONITOR -- requirements
Module: hs_protocol_monitor

---
 rtl/hs_protocol_monitor.sv | 166 ++++++++++++++++
 tb/tb_hs_protocol_monitor.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hs_protocol_monitor.sv
// ============================================================================
// hs_protocol_monitor
//
// Passive checker for NCH independent four-phase req/ack handshakes.
// Each channel follows the cycle IDLE -> REQ -> ACK -> REL -> IDLE. The
// monitor reports completed transfers, flags protocol violations, and flags
// a channel that waits too long for the next handshake step.
//
// Parameters
//   NCH      number of handshake channels (1..16)
//   TOUT_W   width of the timeout limit and per-channel wait counter (2..16)
//
// Ports
//   clk        single clock; all state updates on the rising edge
//   rst_n      asynchronous active-low reset
//   req        [NCH]    per-channel request, synchronous to clk
//   ack        [NCH]    per-channel acknowledge, synchronous to clk
//   tout       [TOUT_W] timeout limit in clk cycles; 0 disables the check
//   clr_err    synchronous clear of all sticky error flags
//   done       [NCH]    one-cycle pulse after each completed transfer
//   busy       [NCH]    channel is not IDLE
//   err_proto  [NCH]    sticky protocol-violation flags
//   err_tout   [NCH]    sticky timeout flags
//   err        OR of all err_proto and err_tout bits
// ============================================================================
module hs_protocol_monitor #(
    parameter int NCH    = 2,
    parameter int TOUT_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NCH-1:0]    req,
    input  logic [NCH-1:0]    ack,
    input  logic [TOUT_W-1:0] tout,
    input  logic              clr_err,
    output logic [NCH-1:0]    done,
    output logic [NCH-1:0]    busy,
    output logic [NCH-1:0]    err_proto,
    output logic [NCH-1:0]    err_tout,
    output logic              err
);

    // State encoding equals the {req, ack} pair that defines the state, so
    // the sampled inputs can be compared with, and resynchronised into, the
    // state register without any decode.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REL  = 2'b01,
        ST_REQ  = 2'b10,
        ST_ACK  = 2'b11
    } state_t;

    // Returns 1 when moving from cur to nxt is one of the four legal steps.
    function automatic logic is_legal(input state_t cur, input state_t nxt);
        logic ok;
        // NOTE: give every combinational result a default before the case so
        // no path leaves it unassigned (which would otherwise infer a latch).
        ok = 1'b0;
        case (cur)
            ST_IDLE: ok = (nxt == ST_REQ);
            ST_REQ:  ok = (nxt == ST_ACK);
            ST_ACK:  ok = (nxt == ST_REL);
            ST_REL:  ok = (nxt == ST_IDLE);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    // ------------------------------------------------------------------------
    // Per-channel state
    // ------------------------------------------------------------------------
    state_t            state_q [NCH];   // handshake FSM state
    logic [TOUT_W-1:0] wait_q  [NCH];   // cycles spent in the current REQ/REL
    logic [NCH-1:0]    flagged_q;       // timeout already reported this phase

    // ------------------------------------------------------------------------
    // Per-channel decode
    // ------------------------------------------------------------------------
    state_t            smp_st [NCH];    // sampled {req, ack} as a state
    logic [NCH-1:0]    changed;         // sampled pair differs from state
    logic [NCH-1:0]    legal;           // change is a legal step
    logic [NCH-1:0]    viol;            // change is a protocol violation
    logic [NCH-1:0]    fin;             // legal REL -> IDLE (transfer done)
    logic [NCH-1:0]    waiting;         // current state is REQ or REL
    logic [NCH-1:0]    tout_hit;        // timeout detected on this edge
    logic [NCH-1:0]    proto_nxt;       // next err_proto value
    logic [NCH-1:0]    tout_nxt;        // next err_tout value
    logic [NCH-1:0]    busy_nxt;        // next busy value
    logic [TOUT_W-1:0] tout_m1;         // compare point for the wait counter

    // Wrap at tout == 0 is harmless: the compare is gated by tout != 0.
    assign tout_m1 = tout - TOUT_W'(1);

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        assign smp_st[i]   = state_t'({req[i], ack[i]});
        assign changed[i]  = (smp_st[i] != state_q[i]);
        assign legal[i]    = changed[i] && is_legal(state_q[i], smp_st[i]);
        assign viol[i]     = changed[i] && !legal[i];
        assign fin[i]      = legal[i] && (state_q[i] == ST_REL);
        assign waiting[i]  = (state_q[i] == ST_REQ) || (state_q[i] == ST_REL);

        // The counter holds the number of edges already spent unchanged in
        // this phase, so equality with tout-1 means this edge is the tout-th
        // consecutive one without a response. Equality (not >=) keeps a
        // lowered tout from flagging retroactively; flagged_q keeps a raised
        // tout from flagging a second time in the same phase.
        assign tout_hit[i] = waiting[i] && !changed[i] && (tout != '0) &&
                             (wait_q[i] == tout_m1) && !flagged_q[i];
    end

    // A detection on the same edge as clr_err wins over the clear.
    assign proto_nxt = (err_proto & {NCH{~clr_err}}) | viol;
    assign tout_nxt  = (err_tout  & {NCH{~clr_err}}) | tout_hit;

    // Whatever happens on an edge, the state that follows it is the sampled
    // pair: unchanged holds, a legal step advances to it, and a violation
    // resynchronises to it. Hence busy follows the sampled inputs directly.
    assign busy_nxt  = req | ack;

    // ------------------------------------------------------------------------
    // Sequential state and registered outputs
    // ------------------------------------------------------------------------
    // NOTE: sequential state is written only with non-blocking assignments so
    // every register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: these per-channel arrays are control state, not data
            // storage, so every element is reset along with the flops.
            for (int i = 0; i < NCH; i++) begin
                state_q[i] <= ST_IDLE;
                wait_q[i]  <= '0;
            end
            flagged_q <= '0;
            done      <= '0;
            busy      <= '0;
            err_proto <= '0;
            err_tout  <= '0;
            err       <= 1'b0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                state_q[i] <= smp_st[i];

                // Cleared on any state change and outside the wait states;
                // otherwise counts up and sticks at all-ones.
                if (changed[i] || !waiting[i]) begin
                    wait_q[i] <= '0;
                end else if (wait_q[i] != '1) begin
                    wait_q[i] <= wait_q[i] + TOUT_W'(1);
                end

                if (changed[i]) begin
                    flagged_q[i] <= 1'b0;
                end else if (tout_hit[i]) begin
                    flagged_q[i] <= 1'b1;
                end
            end

            done      <= fin;
            busy      <= busy_nxt;
            err_proto <= proto_nxt;
            err_tout  <= tout_nxt;
            err       <= |{proto_nxt, tout_nxt};
        end
    end

endmodule

// File: tb/tb_hs_protocol_monitor.sv
// ============================================================================
// tb_hs_protocol_monitor
//
// Self-checking bench for hs_protocol_monitor (NCH=2, TOUT_W=8).
// A table of directed vectors, a few hand-written multi-cycle sequences, and
// a randomized run checked against a phase-index reference model.
// ============================================================================
module tb_hs_protocol_monitor;

    localparam int NCH    = 2;
    localparam int TOUT_W = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NCH-1:0]    req;
    logic [NCH-1:0]    ack;
    logic [TOUT_W-1:0] tout;
    logic              clr_err;
    logic [NCH-1:0]    done;
    logic [NCH-1:0]    busy;
    logic [NCH-1:0]    err_proto;
    logic [NCH-1:0]    err_tout;
    logic              err;

    int n_checks = 0;
    int n_errors = 0;

    hs_protocol_monitor #(.NCH(NCH), .TOUT_W(TOUT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .ack       (ack),
        .tout      (tout),
        .clr_err   (clr_err),
        .done      (done),
        .busy      (busy),
        .err_proto (err_proto),
        .err_tout  (err_tout),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Watchdog: the whole run is a few thousand cycles.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Reference model: handshake position is an index 0..3 around the ring
    // IDLE(00) REQ(10) ACK(11) REL(01); a legal move is index+1 mod 4.
    // ------------------------------------------------------------------------
    int             m_ph [NCH];   // phase index of last sampled pair
    int             m_n  [NCH];   // consecutive unchanged edges in REQ/REL
    bit             m_fl [NCH];   // timeout already reported in this phase
    logic [NCH-1:0] m_done, m_busy, m_ep, m_et;
    logic           m_err;

    function automatic int phase_of(input logic r, input logic a);
        if (!r && !a) return 0;
        if ( r && !a) return 1;
        if ( r &&  a) return 2;
        return 3;
    endfunction

    function automatic logic [1:0] pair_of(input int p);
        case (p)
            0:       return 2'b00;
            1:       return 2'b10;
            2:       return 2'b11;
            default: return 2'b01;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_ph[i] = 0;
            m_n[i]  = 0;
            m_fl[i] = 1'b0;
        end
        m_done = '0; m_busy = '0; m_ep = '0; m_et = '0; m_err = 1'b0;
    endtask

    task automatic model_edge();
        for (int i = 0; i < NCH; i++) begin
            int   p_new;
            logic set_p, set_t, fin;
            p_new = phase_of(req[i], ack[i]);
            set_p = 1'b0; set_t = 1'b0; fin = 1'b0;
            if (p_new == m_ph[i]) begin
                if (m_ph[i] == 1 || m_ph[i] == 3) begin
                    m_n[i]++;
                    if (!m_fl[i] && tout != 0 && m_n[i] == int'(tout)) begin
                        set_t   = 1'b1;
                        m_fl[i] = 1'b1;
                    end
                end
            end else begin
                m_n[i]  = 0;
                m_fl[i] = 1'b0;
                if (p_new == (m_ph[i] + 1) % 4) fin = (m_ph[i] == 3);
                else                            set_p = 1'b1;
            end
            m_ph[i]   = p_new;
            m_done[i] = fin;
            m_busy[i] = (p_new != 0);
            m_ep[i]   = (m_ep[i] & ~clr_err) | set_p;
            m_et[i]   = (m_et[i] & ~clr_err) | set_t;
        end
        m_err = |{m_ep, m_et};
    endtask

    task automatic compare_model(input string tag);
        check({tag, ".done"},      32'(done),      32'(m_done));
        check({tag, ".busy"},      32'(busy),      32'(m_busy));
        check({tag, ".err_proto"}, 32'(err_proto), 32'(m_ep));
        check({tag, ".err_tout"},  32'(err_tout),  32'(m_et));
        check({tag, ".err"},       32'(err),       32'(m_err));
    endtask

    // One clock: inputs already driven; model follows the edge, outputs are
    // sampled 1 time unit later.
    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        compare_model(tag);
    endtask

    // ------------------------------------------------------------------------
    // Directed vector table
    // ------------------------------------------------------------------------
    typedef struct {
        logic [NCH-1:0]    req;
        logic [NCH-1:0]    ack;
        logic [TOUT_W-1:0] tout;
        logic              clr;
        logic [NCH-1:0]    done;
        logic [NCH-1:0]    busy;
        logic [NCH-1:0]    ep;
        logic [NCH-1:0]    et;
    } vec_t;

    vec_t tbl[$];

    initial begin
        // Legal handshake on channel 0 at 2-cycle spacing, tout=4.
        //              req    ack    tout  clr   done   busy   ep     et
        tbl.push_back('{2'b00, 2'b00, 8'd4, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00});
        tbl.push_back('{2'b01, 2'b00, 8'd4, 1'b0, 2'b00, 2'b01, 2'b00, 2'b00});
        tbl.push_back('{2'b01, 2'b00, 8'd4, 1'b0, 2'b00, 2'b01, 2'b00, 2'b00});
        tbl.push_back('{2'b01, 2'b01, 8'd4, 1'b0, 2'b00, 2'b01, 2'b00, 2'b00});
        tbl.push_back('{2'b01, 2'b01, 8'd4, 1'b0, 2'b00, 2'b01, 2'b00, 2'b00});
        tbl.push_back('{2'b00, 2'b01, 8'd4, 1'b0, 2'b00, 2'b01, 2'b00, 2'b00});
        tbl.push_back('{2'b00, 2'b01, 8'd4, 1'b0, 2'b00, 2'b01, 2'b00, 2'b00});
        tbl.push_back('{2'b00, 2'b00, 8'd4, 1'b0, 2'b01, 2'b00, 2'b00, 2'b00});
        tbl.push_back('{2'b00, 2'b00, 8'd4, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00});
        // ack rise in IDLE -> violation, resync to REL.
        tbl.push_back('{2'b00, 2'b01, 8'd4, 1'b0, 2'b00, 2'b01, 2'b01, 2'b00});
        tbl.push_back('{2'b00, 2'b01, 8'd4, 1'b1, 2'b00, 2'b01, 2'b00, 2'b00});
        // From the resynchronised REL, ack fall is a legal completion.
        tbl.push_back('{2'b00, 2'b00, 8'd4, 1'b0, 2'b01, 2'b00, 2'b00, 2'b00});
        // req drop in REQ -> violation, resync to IDLE.
        tbl.push_back('{2'b01, 2'b00, 8'd4, 1'b0, 2'b00, 2'b01, 2'b00, 2'b00});
        tbl.push_back('{2'b00, 2'b00, 8'd4, 1'b0, 2'b00, 2'b00, 2'b01, 2'b00});
        tbl.push_back('{2'b00, 2'b00, 8'd4, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00});
        // req and ack both drop in ACK -> violation, resync to IDLE, no done.
        tbl.push_back('{2'b01, 2'b00, 8'd4, 1'b0, 2'b00, 2'b01, 2'b00, 2'b00});
        tbl.push_back('{2'b01, 2'b01, 8'd4, 1'b0, 2'b00, 2'b01, 2'b00, 2'b00});
        tbl.push_back('{2'b00, 2'b00, 8'd4, 1'b0, 2'b00, 2'b00, 2'b01, 2'b00});
        tbl.push_back('{2'b00, 2'b00, 8'd4, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00});
    end

    // ------------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------------
    initial begin
        rst_n   = 1'b0;
        req     = '0;
        ack     = '0;
        tout    = 8'd4;
        clr_err = 1'b0;
        model_reset();

        // Reset state, observed while reset is held across clock edges.
        repeat (3) @(posedge clk);
        #1;
        compare_model("reset");
        #2 rst_n = 1'b1;

        // ---- Table-driven vectors ----
        for (int k = 0; k < tbl.size(); k++) begin
            req     = tbl[k].req;
            ack     = tbl[k].ack;
            tout    = tbl[k].tout;
            clr_err = tbl[k].clr;
            @(posedge clk);
            model_edge();
            #1;
            check($sformatf("tbl%0d.done", k),      32'(done),      32'(tbl[k].done));
            check($sformatf("tbl%0d.busy", k),      32'(busy),      32'(tbl[k].busy));
            check($sformatf("tbl%0d.err_proto", k), 32'(err_proto), 32'(tbl[k].ep));
            check($sformatf("tbl%0d.err_tout", k),  32'(err_tout),  32'(tbl[k].et));
            check($sformatf("tbl%0d.err", k),       32'(err),       32'(|{tbl[k].ep, tbl[k].et}));
        end
        clr_err = 1'b0;

        // ---- Timeout on channel 1, tout=4 ----
        tout = 8'd4;
        req  = 2'b10;
        step("to_entry");
        for (int k = 1; k <= 4; k++) begin
            step("to_wait");
            check($sformatf("to_edge%0d", k), 32'(err_tout[1]), 32'(k == 4));
        end
        for (int k = 0; k < 5; k++) begin
            step("to_hold");
            check("to_sticky", 32'(err_tout[1]), 32'd1);
        end
        clr_err = 1'b1;
        step("to_clr");
        check("to_clr_et", 32'(err_tout), 32'd0);
        clr_err = 1'b0;
        // Same wait phase: already reported, so no second flag.
        repeat (6) step("to_noreflag");
        check("to_noreflag_et", 32'(err_tout), 32'd0);
        ack = 2'b10; step("to_ack");
        req = 2'b00; step("to_rel");
        ack = 2'b00; step("to_idle");
        check("to_done", 32'(done), 32'b10);

        // ---- Timeout disabled: tout=0, hold 100 cycles ----
        tout = 8'd0;
        req  = 2'b10;
        step("t0_entry");
        repeat (100) step("t0_wait");
        check("t0_no_flag", 32'(err_tout), 32'd0);
        ack = 2'b10; step("t0_ack");
        req = 2'b00; step("t0_rel");
        ack = 2'b00; step("t0_idle");

        // ---- Concurrency: ch1 times out, both complete on the same edge ----
        tout = 8'd3;
        req  = 2'b11; ack = 2'b00; step("cc_req");
        ack  = 2'b01; step("cc_ack0");
        step("cc_w2");
        step("cc_w3");
        check("cc_tout1", 32'(err_tout), 32'b10);
        ack  = 2'b11; step("cc_ack1");
        req  = 2'b00; step("cc_rel");
        ack  = 2'b00; step("cc_idle");
        check("cc_done_both", 32'(done), 32'b11);
        check("cc_et_indep",  32'(err_tout), 32'b10);
        check("cc_ep_clean",  32'(err_proto), 32'b00);
        step("cc_after");
        check("cc_done_pulse", 32'(done), 32'b00);

        // ---- Clear priority ----
        ack = 2'b01; step("cp_v0");
        check("cp_ep0", 32'(err_proto), 32'b01);
        clr_err = 1'b1;
        ack = 2'b11; step("cp_clr_and_v1");
        check("cp_ep_win",  32'(err_proto), 32'b10);
        check("cp_et_clr",  32'(err_tout),  32'b00);
        step("cp_clr_only");
        check("cp_all_clear", 32'({err, err_proto, err_tout}), 32'd0);
        clr_err = 1'b0;
        ack = 2'b00; step("cp_idle");

        // ---- Reset in the middle of a transfer ----
        req = 2'b01; step("rs_req");
        ack = 2'b11; step("rs_ack");   // ch0 -> ACK, ch1 ack rise in IDLE
        check("rs_pre_busy", 32'(busy), 32'b11);
        check("rs_pre_err",  32'(err),  32'd1);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check("rs_async_done", 32'(done),      32'd0);
        check("rs_async_busy", 32'(busy),      32'd0);
        check("rs_async_ep",   32'(err_proto), 32'd0);
        check("rs_async_et",   32'(err_tout),  32'd0);
        check("rs_async_err",  32'(err),       32'd0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        step("rs_first");
        check("rs_first_ep0", 32'(err_proto[0]), 32'd1);
        req = 2'b00; step("rs_rel");
        ack = 2'b00; step("rs_idle");
        clr_err = 1'b1; step("rs_clr");
        clr_err = 1'b0;

        // ---- Randomized run against the model ----
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 49) == 0) tout = TOUT_W'($urandom_range(0, 6));
            clr_err = ($urandom_range(0, 19) == 0);
            for (int i = 0; i < NCH; i++) begin
                int          r;
                logic [1:0]  pr;
                r = int'($urandom_range(0, 99));
                if (r < 50)      pr = pair_of(m_ph[i]);
                else if (r < 85) pr = pair_of((m_ph[i] + 1) % 4);
                else             pr = pair_of(int'($urandom_range(0, 3)));
                req[i] = pr[1];
                ack[i] = pr[0];
            end
            step("rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
